svm_vec_packer: RTL
===================

// Module: svm_vec_packer
// PURPOSE
//  Producer side of the SVM feature FIFO. Accepts the feature byte stream over a valid/ready handshake.
//  Packs 16 bytes into each 128-bit FIFO word and writes exactly VEC_LEN/16 words per vector.
//  Short vectors are zero-padded and over-long vectors are truncated, so the classifier always sees
//  whole vectors. Sits between the feature source (DMA/stream) and the FIFO feeding the SVM engine.
// PARAMETERS
//  VEC_LEN  8192  bytes per feature vector; multiple of 16, <= 65535
//  CNT_W    16    width of byte counter and vec_count
// PORTS
//  clk        in   1    clock; all logic on posedge
//  reset      in   1    synchronous, active-high
//  in_data    in   8    feature byte (signed 8-bit value, passed through untouched)
//  in_valid   in   1    in_data valid
//  in_last    in   1    marks last byte of a vector; qualified by in_valid
//  in_ready   out  1    block accepts a byte this cycle
//  wr_data    out  128  FIFO write word
//  wr_en      out  1    FIFO write strobe
//  wr_full    in   1    FIFO full
//  vec_done   out  1    1-cycle pulse: all VEC_LEN/16 words of a vector written
//  short_err  out  1    1-cycle pulse with vec_done: in_last arrived before VEC_LEN bytes
//  long_err   out  1    1-cycle pulse with vec_done: VEC_LEN bytes taken without in_last
//  vec_count  out  16   vectors completed; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=FILL; word buffer, byte_cnt and lane index cleared. Outputs after reset:
//   in_ready=1, wr_en=0, wr_data=0, vec_done=0, short_err=0, long_err=0, vec_count=0.
//  Reset mid-vector: the partial word is discarded and no wr_en is issued.
//  Byte accept = in_valid & in_ready.
//  Lane mapping: the k-th accepted byte of a word goes to wr_data[8k+7:8k].
//   The first byte of a vector lands in bits [7:0].
//  Buffer zeroing: the word buffer is cleared after every push.
//   Lanes never written stay 0.
//  States:
//   FILL: in_ready=1. Each accept stores the byte, then lane++ and byte_cnt++.
//    Go to PUSH when any of these is accepted: lane 15, a byte with in_last, or byte number VEC_LEN.
//    Latch the pending error flag at that point:
//     - in_last with byte_cnt+1 < VEC_LEN: short pending.
//     - byte VEC_LEN without in_last: long pending.
//  PUSH: in_ready=0; wr_en = ~wr_full (combinational); wr_data held stable.
//   If wr_full=1: stay in PUSH and hold wr_data.
//   On the write edge:
//    - byte_cnt == VEC_LEN: go to DONE.
//    - short pending: go to PAD.
//    - otherwise: go to FILL.
//  PAD: in_ready=0. Sets wr_data=0, byte_cnt += 16, then goes to PUSH.
//   Repeats until byte_cnt == VEC_LEN.
//  DONE: one cycle. vec_done=1; short_err/long_err driven from the pending flag; vec_count++.
//   byte_cnt, lane and flags are cleared.
//   Next state: DISCARD if long pending, else FILL.
//  DISCARD: in_ready=1, bytes are dropped and nothing is written. Leave for FILL after accepting in_last.
//  Latency: last byte of a word accepted in cycle N gives wr_en at cycle N+1 at the earliest.
//   Peak rate: 17 cycles per word.
//  Simultaneous events:
//   - in_last on byte VEC_LEN is a normal end with no error.
//   - in_last on lane 15 with byte_cnt < VEC_LEN: push the word, then PAD.
//   - A vector is never split across vec_done boundaries; the FIFO always receives VEC_LEN/16 words.
//  Width: byte_cnt is CNT_W bits and compared with == VEC_LEN, so it never wraps within a vector.
// TESTING
//  1. 8192 bytes, byte i = i mod 256, last on byte 8192, wr_full=0.
//     -> 512 wr_en; word0 = 0x0F0E..0100; vec_done once; vec_count=1; no err.
//  2. Test 1 with wr_full=1 for 5 cycles during a PUSH.
//     -> wr_en=0 and wr_data stable for those 5 cycles; in_ready=0; no byte lost or duplicated.
//  3. 20 bytes, last on byte 20.
//     -> word1 = bytes 16-19 in [31:0], rest 0; 510 zero words; 512 writes total; short_err=1 with vec_done.
//  4. 8200 bytes, last on byte 8200.
//     -> 512 writes; long_err=1 with vec_done; 8 bytes dropped; next vector word0 correct.
//  5. reset after 100 bytes accepted, then a new full vector.
//     -> no wr_en during reset; vec_count=0 then 1; 512 writes of new data only.
//  6. Test 1 with random in_valid gaps (about 50%).
//     -> FIFO contents identical to test 1.

Source files
------------

// File: rtl/svm_vec_packer.sv
// Producer side of the SVM feature FIFO: packs a byte stream into 128-bit words,
// always emitting exactly VEC_LEN/16 words per vector (zero-padded or truncated).
module svm_vec_packer #(
  parameter int unsigned VEC_LEN = 8192,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [127:0]     wr_data,
  output logic             wr_en,
  input  logic             wr_full,
  output logic             vec_done,
  output logic             short_err,
  output logic             long_err,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [2:0] {
    S_FILL,
    S_PUSH,
    S_PAD,
    S_DONE,
    S_DISCARD
  } state_e;

  localparam logic [CNT_W-1:0] VecLenC = CNT_W'(VEC_LEN);

  state_e             state_q;
  logic [127:0]       buf_q;
  logic [3:0]         lane_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic               short_pend_q;
  logic               long_pend_q;
  logic               vec_done_q;
  logic               short_err_q;
  logic               long_err_q;
  logic [CNT_W-1:0]   vec_count_q;

  logic [CNT_W-1:0]   byte_cnt_d;
  logic [CNT_W-1:0]   byte_cnt_rnd_d;
  logic               end_of_len;
  logic               word_end;

  always_comb begin
    byte_cnt_d     = byte_cnt_q + CNT_W'(1);
    // A short vector counts its unwritten lanes, so padding proceeds on word boundaries.
    byte_cnt_rnd_d = {byte_cnt_d[CNT_W-1:4] + (CNT_W-4)'(|byte_cnt_d[3:0]), 4'b0000};
    end_of_len     = (byte_cnt_d == VecLenC);
    word_end       = (lane_q == 4'hF) || in_last || end_of_len;
  end

  assign in_ready  = (state_q == S_FILL) || (state_q == S_DISCARD);
  assign wr_en     = (state_q == S_PUSH) && !wr_full;
  assign wr_data   = buf_q;
  assign vec_done  = vec_done_q;
  assign short_err = short_err_q;
  assign long_err  = long_err_q;
  assign vec_count = vec_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      buf_q        <= '0;
      lane_q       <= '0;
      byte_cnt_q   <= '0;
      short_pend_q <= 1'b0;
      long_pend_q  <= 1'b0;
      vec_done_q   <= 1'b0;
      short_err_q  <= 1'b0;
      long_err_q   <= 1'b0;
      vec_count_q  <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only on the cycle entering DONE.
      vec_done_q  <= 1'b0;
      short_err_q <= 1'b0;
      long_err_q  <= 1'b0;

      unique case (state_q)
        S_FILL: begin
          if (in_valid) begin
            buf_q[{lane_q, 3'b000} +: 8] <= in_data;
            lane_q     <= lane_q + 4'd1;
            byte_cnt_q <= byte_cnt_d;
            if (word_end) begin
              state_q      <= S_PUSH;
              short_pend_q <= in_last && !end_of_len;
              long_pend_q  <= !in_last && end_of_len;
              if (in_last && !end_of_len) begin
                byte_cnt_q <= byte_cnt_rnd_d;
              end
            end
          end
        end

        S_PUSH: begin
          if (!wr_full) begin
            buf_q  <= '0;
            lane_q <= '0;
            if (byte_cnt_q == VecLenC) begin
              state_q     <= S_DONE;
              vec_done_q  <= 1'b1;
              short_err_q <= short_pend_q;
              long_err_q  <= long_pend_q;
              vec_count_q <= vec_count_q + CNT_W'(1);
            end else if (short_pend_q) begin
              state_q <= S_PAD;
            end else begin
              state_q <= S_FILL;
            end
          end
        end

        S_PAD: begin
          byte_cnt_q <= byte_cnt_q + CNT_W'(16);
          state_q    <= S_PUSH;
        end

        S_DONE: begin
          byte_cnt_q   <= '0;
          lane_q       <= '0;
          short_pend_q <= 1'b0;
          long_pend_q  <= 1'b0;
          state_q      <= long_pend_q ? S_DISCARD : S_FILL;
        end

        S_DISCARD: begin
          if (in_valid && in_last) begin
            state_q <= S_FILL;
          end
        end

        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule
